// File: rtl/alu_reservation_station.sv
// ---------------------------------------------------------------------------
// alu_reservation_station
// Holds dispatched ALU operations until both operands are available, snooping
// the common data bus for pending producer tags, then issues the lowest-index
// ready entry to the ALU.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   flush                    discard every held entry
//   dispatch_*               incoming operation, operands as value or tag
//   dispatch_ready           at least one free entry (registered state only)
//   cdb_req/cdb_tag/cdb_data result broadcast snooped for waiting operands
//   issue_valid/issue_ready  issue handshake toward the ALU
//   issue_*                  selected entry fields, zero when nothing issues
//   free_count               number of unoccupied entries
// ---------------------------------------------------------------------------
module alu_reservation_station #(
  parameter int unsigned NUM_ENTRIES = 4,
  parameter int unsigned TAG_W       = 3
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        flush,
  input  logic                        dispatch_valid,
  output logic                        dispatch_ready,
  input  logic                        dispatch_arith,
  input  logic [2:0]                  dispatch_funct3,
  input  logic                        dispatch_funct7,
  input  logic [TAG_W-1:0]            dispatch_dest_tag,
  input  logic                        dispatch_src1_valid,
  input  logic [31:0]                 dispatch_src1_data,
  input  logic [TAG_W-1:0]            dispatch_src1_tag,
  input  logic                        dispatch_src2_valid,
  input  logic [31:0]                 dispatch_src2_data,
  input  logic [TAG_W-1:0]            dispatch_src2_tag,
  input  logic                        cdb_req,
  input  logic [TAG_W-1:0]            cdb_tag,
  input  logic [31:0]                 cdb_data,
  output logic                        issue_valid,
  input  logic                        issue_ready,
  output logic                        issue_arith,
  output logic [31:0]                 issue_src1,
  output logic [31:0]                 issue_src2,
  output logic [2:0]                  issue_funct3,
  output logic                        issue_funct7,
  output logic [TAG_W-1:0]            issue_tag,
  output logic [$clog2(NUM_ENTRIES):0] free_count
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned IDX_W  = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1;
  localparam int unsigned CNT_W  = $clog2(NUM_ENTRIES) + 1;

  typedef struct packed {
    logic              busy;
    logic              arith;
    logic [2:0]        funct3;
    logic              funct7;
    logic [TAG_W-1:0]  dest;
    logic              s1_rdy;
    logic [DATA_W-1:0] s1_val;
    logic [TAG_W-1:0]  s1_tag;
    logic              s2_rdy;
    logic [DATA_W-1:0] s2_val;
    logic [TAG_W-1:0]  s2_tag;
  } entry_t;

  entry_t [NUM_ENTRIES-1:0] r_ent;
  entry_t [NUM_ENTRIES-1:0] w_ent_nxt;
  entry_t                   w_disp_ent;

  logic [CNT_W-1:0] w_busy_cnt;
  logic             w_free_found;
  logic [IDX_W-1:0] w_free_idx;
  logic             w_sel_found;
  logic [IDX_W-1:0] w_sel_idx;
  logic             w_disp_fire;
  logic             w_issue_fire;

  // Occupancy count, lowest free slot and lowest eligible slot from registered state
  always_comb begin : status
    w_busy_cnt   = '0;
    w_free_found = 1'b0;
    w_free_idx   = '0;
    w_sel_found  = 1'b0;
    w_sel_idx    = '0;
    for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
      w_busy_cnt = w_busy_cnt + CNT_W'(r_ent[i].busy);
      if (!r_ent[i].busy && !w_free_found) begin
        w_free_found = 1'b1;
        w_free_idx   = IDX_W'(i);
      end
      if (r_ent[i].busy && r_ent[i].s1_rdy && r_ent[i].s2_rdy && !w_sel_found) begin
        w_sel_found = 1'b1;
        w_sel_idx   = IDX_W'(i);
      end
    end
  end

  assign free_count     = CNT_W'(NUM_ENTRIES) - w_busy_cnt;
  assign dispatch_ready = (free_count != '0);
  assign issue_valid    = w_sel_found;

  assign w_disp_fire  = dispatch_valid && dispatch_ready;
  assign w_issue_fire = issue_valid && issue_ready;

  // Issue fields come straight from the selected entry; zero when idle
  always_comb begin : issue_out
    issue_arith  = 1'b0;
    issue_src1   = '0;
    issue_src2   = '0;
    issue_funct3 = '0;
    issue_funct7 = 1'b0;
    issue_tag    = '0;
    if (w_sel_found) begin
      issue_arith  = r_ent[w_sel_idx].arith;
      issue_src1   = r_ent[w_sel_idx].s1_val;
      issue_src2   = r_ent[w_sel_idx].s2_val;
      issue_funct3 = r_ent[w_sel_idx].funct3;
      issue_funct7 = r_ent[w_sel_idx].funct7;
      issue_tag    = r_ent[w_sel_idx].dest;
    end
  end

  // New entry image: operand taken from dispatch value, else a same-cycle CDB hit, else wait on tag
  always_comb begin : disp_entry
    w_disp_ent        = '0;
    w_disp_ent.busy   = 1'b1;
    w_disp_ent.arith  = dispatch_arith;
    w_disp_ent.funct3 = dispatch_funct3;
    w_disp_ent.funct7 = dispatch_funct7;
    w_disp_ent.dest   = dispatch_dest_tag;
    w_disp_ent.s1_tag = dispatch_src1_tag;
    w_disp_ent.s2_tag = dispatch_src2_tag;
    if (dispatch_src1_valid) begin
      w_disp_ent.s1_rdy = 1'b1;
      w_disp_ent.s1_val = dispatch_src1_data;
    end else if (cdb_req && (cdb_tag == dispatch_src1_tag)) begin
      w_disp_ent.s1_rdy = 1'b1;
      w_disp_ent.s1_val = cdb_data;
    end
    if (dispatch_src2_valid) begin
      w_disp_ent.s2_rdy = 1'b1;
      w_disp_ent.s2_val = dispatch_src2_data;
    end else if (cdb_req && (cdb_tag == dispatch_src2_tag)) begin
      w_disp_ent.s2_rdy = 1'b1;
      w_disp_ent.s2_val = cdb_data;
    end
  end

  // Next entry state: flush wins; otherwise CDB wakeup, issue retirement and dispatch all apply.
  // The dispatch slot is chosen from registered state, so it never aliases the issued slot.
  always_comb begin : next_state
    w_ent_nxt = r_ent;
    if (flush) begin
      for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
        w_ent_nxt[i].busy = 1'b0;
      end
    end else begin
      if (cdb_req) begin
        for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
          if (r_ent[i].busy) begin
            if (!r_ent[i].s1_rdy && (r_ent[i].s1_tag == cdb_tag)) begin
              w_ent_nxt[i].s1_rdy = 1'b1;
              w_ent_nxt[i].s1_val = cdb_data;
            end
            if (!r_ent[i].s2_rdy && (r_ent[i].s2_tag == cdb_tag)) begin
              w_ent_nxt[i].s2_rdy = 1'b1;
              w_ent_nxt[i].s2_val = cdb_data;
            end
          end
        end
      end
      if (w_issue_fire) begin
        w_ent_nxt[w_sel_idx].busy = 1'b0;
      end
      if (w_disp_fire) begin
        w_ent_nxt[w_free_idx] = w_disp_ent;
      end
    end
  end

  // Entry storage
  always_ff @(posedge clk) begin : state_reg
    if (rst) begin
      r_ent <= '0;
    end else begin
      r_ent <= w_ent_nxt;
    end
  end

endmodule

// File: tb/tb_alu_reservation_station.sv
// ---------------------------------------------------------------------------
// tb_alu_reservation_station
// Directed scenarios followed by randomized traffic; every cycle the outputs
// are compared with a slot-level behavioural model of the station.
// ---------------------------------------------------------------------------
module tb_alu_reservation_station;

  localparam int NE = 4;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        dispatch_valid;
  logic        dispatch_ready;
  logic        dispatch_arith;
  logic [2:0]  dispatch_funct3;
  logic        dispatch_funct7;
  logic [2:0]  dispatch_dest_tag;
  logic        dispatch_src1_valid;
  logic [31:0] dispatch_src1_data;
  logic [2:0]  dispatch_src1_tag;
  logic        dispatch_src2_valid;
  logic [31:0] dispatch_src2_data;
  logic [2:0]  dispatch_src2_tag;
  logic        cdb_req;
  logic [2:0]  cdb_tag;
  logic [31:0] cdb_data;
  logic        issue_valid;
  logic        issue_ready;
  logic        issue_arith;
  logic [31:0] issue_src1;
  logic [31:0] issue_src2;
  logic [2:0]  issue_funct3;
  logic        issue_funct7;
  logic [2:0]  issue_tag;
  logic [2:0]  free_count;

  int checks = 0;
  int errors = 0;

  alu_reservation_station #(.NUM_ENTRIES(NE), .TAG_W(3)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .dispatch_valid(dispatch_valid), .dispatch_ready(dispatch_ready),
    .dispatch_arith(dispatch_arith), .dispatch_funct3(dispatch_funct3),
    .dispatch_funct7(dispatch_funct7), .dispatch_dest_tag(dispatch_dest_tag),
    .dispatch_src1_valid(dispatch_src1_valid), .dispatch_src1_data(dispatch_src1_data),
    .dispatch_src1_tag(dispatch_src1_tag),
    .dispatch_src2_valid(dispatch_src2_valid), .dispatch_src2_data(dispatch_src2_data),
    .dispatch_src2_tag(dispatch_src2_tag),
    .cdb_req(cdb_req), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_arith(issue_arith), .issue_src1(issue_src1), .issue_src2(issue_src2),
    .issue_funct3(issue_funct3), .issue_funct7(issue_funct7), .issue_tag(issue_tag),
    .free_count(free_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: one record per slot holding what the station must remember
  typedef struct {
    bit        busy;
    bit        arith;
    bit [2:0]  f3;
    bit        f7;
    bit [2:0]  dest;
    bit        r1;
    bit [31:0] v1;
    bit [2:0]  t1;
    bit        r2;
    bit [31:0] v2;
    bit [2:0]  t2;
  } m_ent_t;

  m_ent_t m [NE];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    flush = 0; dispatch_valid = 0; dispatch_arith = 0; dispatch_funct3 = 0;
    dispatch_funct7 = 0; dispatch_dest_tag = 0;
    dispatch_src1_valid = 0; dispatch_src1_data = 0; dispatch_src1_tag = 0;
    dispatch_src2_valid = 0; dispatch_src2_data = 0; dispatch_src2_tag = 0;
    cdb_req = 0; cdb_tag = 0; cdb_data = 0; issue_ready = 0;
  endtask

  task automatic disp(input bit ar, input bit [2:0] f3, input bit f7, input bit [2:0] dest,
                      input bit v1, input bit [31:0] d1, input bit [2:0] t1,
                      input bit v2, input bit [31:0] d2, input bit [2:0] t2);
    dispatch_valid = 1; dispatch_arith = ar; dispatch_funct3 = f3; dispatch_funct7 = f7;
    dispatch_dest_tag = dest;
    dispatch_src1_valid = v1; dispatch_src1_data = d1; dispatch_src1_tag = t1;
    dispatch_src2_valid = v2; dispatch_src2_data = d2; dispatch_src2_tag = t2;
  endtask

  // Compare outputs against the model, advance the model with the current inputs, then clock
  task automatic tick();
    int sel;
    int nfree;
    int slot;
    m_ent_t nx [NE];
    nfree = 0;
    sel = -1;
    for (int i = 0; i < NE; i++) begin
      if (!m[i].busy) nfree++;
      else if (sel < 0 && m[i].r1 && m[i].r2) sel = i;
    end
    chk("free_count", free_count, nfree);
    chk("dispatch_ready", dispatch_ready, (nfree != 0));
    chk("issue_valid", issue_valid, (sel >= 0));
    if (sel >= 0) begin
      chk("issue_arith", issue_arith, m[sel].arith);
      chk("issue_src1", issue_src1, m[sel].v1);
      chk("issue_src2", issue_src2, m[sel].v2);
      chk("issue_funct3", issue_funct3, m[sel].f3);
      chk("issue_funct7", issue_funct7, m[sel].f7);
      chk("issue_tag", issue_tag, m[sel].dest);
    end else begin
      chk("idle_fields", {issue_arith, issue_funct7, issue_funct3, issue_tag}, 0);
      chk("idle_src1", issue_src1, 0);
      chk("idle_src2", issue_src2, 0);
    end
    nx = m;
    if (rst) begin
      for (int i = 0; i < NE; i++) nx[i] = '{default: 0};
    end else if (flush) begin
      for (int i = 0; i < NE; i++) nx[i].busy = 0;
    end else begin
      if (cdb_req) begin
        for (int i = 0; i < NE; i++) begin
          if (m[i].busy && !m[i].r1 && m[i].t1 == cdb_tag) begin nx[i].r1 = 1; nx[i].v1 = cdb_data; end
          if (m[i].busy && !m[i].r2 && m[i].t2 == cdb_tag) begin nx[i].r2 = 1; nx[i].v2 = cdb_data; end
        end
      end
      if (sel >= 0 && issue_ready) nx[sel].busy = 0;
      if (dispatch_valid && nfree != 0) begin
        slot = -1;
        for (int i = 0; i < NE; i++) if (slot < 0 && !m[i].busy) slot = i;
        nx[slot] = '{default: 0};
        nx[slot].busy = 1; nx[slot].arith = dispatch_arith;
        nx[slot].f3 = dispatch_funct3; nx[slot].f7 = dispatch_funct7;
        nx[slot].dest = dispatch_dest_tag;
        nx[slot].t1 = dispatch_src1_tag; nx[slot].t2 = dispatch_src2_tag;
        if (dispatch_src1_valid) begin nx[slot].r1 = 1; nx[slot].v1 = dispatch_src1_data; end
        else if (cdb_req && cdb_tag == dispatch_src1_tag) begin nx[slot].r1 = 1; nx[slot].v1 = cdb_data; end
        if (dispatch_src2_valid) begin nx[slot].r2 = 1; nx[slot].v2 = dispatch_src2_data; end
        else if (cdb_req && cdb_tag == dispatch_src2_tag) begin nx[slot].r2 = 1; nx[slot].v2 = cdb_data; end
      end
    end
    m = nx;
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle();
    rst = 1;
    for (int i = 0; i < NE; i++) m[i] = '{default: 0};
    repeat (2) @(posedge clk);
    #1;
    rst = 0;

    // Post-reset state
    chk("rst_issue_valid", issue_valid, 0);
    chk("rst_free_count", free_count, NE);
    chk("rst_dispatch_ready", dispatch_ready, 1);
    chk("rst_issue_src1", issue_src1, 0);
    chk("rst_issue_tag", issue_tag, 0);

    // Both operands ready: issues one cycle after dispatch
    disp(1, 0, 0, 2, 1, 5, 0, 1, 7, 0); issue_ready = 1;
    tick();
    idle(); issue_ready = 1;
    chk("ready_issue_valid", issue_valid, 1);
    chk("ready_issue_src1", issue_src1, 5);
    chk("ready_issue_src2", issue_src2, 7);
    chk("ready_issue_tag", issue_tag, 2);
    tick();
    chk("ready_free_after", free_count, 4);

    // Operand waits on tag 3, woken by a later broadcast
    idle();
    disp(1, 0, 0, 1, 0, 0, 3, 1, 1, 0);
    tick();
    idle();
    tick();
    cdb_req = 1; cdb_tag = 3; cdb_data = 32'h10;
    chk("wake_not_yet", issue_valid, 0);
    tick();
    idle(); issue_ready = 1;
    chk("wake_issue_valid", issue_valid, 1);
    chk("wake_issue_src1", issue_src1, 32'h10);
    chk("wake_issue_src2", issue_src2, 1);
    tick();

    // Dispatch bypass from a same-cycle broadcast
    idle();
    disp(0, 3, 0, 6, 0, 0, 4, 1, 2, 0);
    cdb_req = 1; cdb_tag = 4; cdb_data = 32'hAB;
    tick();
    idle(); issue_ready = 1;
    chk("bypass_issue_valid", issue_valid, 1);
    chk("bypass_issue_src1", issue_src1, 32'hAB);
    tick();

    // Fill all slots, overflow dispatch ignored, wake slots 1 and 3 in order
    for (int i = 0; i < NE; i++) begin
      idle();
      disp(1, 0, 0, 3'(4 + i), 0, 0, (i % 2 == 1) ? 3'd6 : 3'd7, 1, 32'(i), 0);
      tick();
    end
    idle();
    chk("full_dispatch_ready", dispatch_ready, 0);
    chk("full_free_count", free_count, 0);
    disp(1, 0, 0, 1, 1, 9, 0, 1, 9, 0);
    tick();
    idle();
    chk("full_ignored_free", free_count, 0);
    chk("full_ignored_valid", issue_valid, 0);
    cdb_req = 1; cdb_tag = 6; cdb_data = 32'h66; issue_ready = 1;
    tick();
    idle(); issue_ready = 1;
    chk("order_first_valid", issue_valid, 1);
    chk("order_first_tag", issue_tag, 5);
    chk("order_first_src1", issue_src1, 32'h66);
    tick();
    chk("order_second_tag", issue_tag, 7);
    tick();
    chk("order_done_valid", issue_valid, 0);
    chk("order_done_free", free_count, 2);

    // Flush overrides concurrent dispatch and broadcast
    idle();
    disp(0, 0, 0, 1, 0, 0, 7, 1, 3, 0);
    tick();
    idle();
    chk("preflush_free", free_count, 1);
    flush = 1; cdb_req = 1; cdb_tag = 7; cdb_data = 32'h77;
    disp(1, 0, 0, 2, 1, 1, 0, 1, 1, 0);
    tick();
    idle();
    chk("flush_free", free_count, 4);
    chk("flush_valid", issue_valid, 0);
    tick();
    chk("flush_still_empty", issue_valid, 0);

    // Back-pressure: entry held with stable fields until accepted
    idle();
    disp(0, 5, 1, 3, 1, 32'h11, 0, 1, 32'h22, 0);
    tick();
    idle();
    for (int i = 0; i < 3; i++) begin
      chk("hold_valid", issue_valid, 1);
      chk("hold_src1", issue_src1, 32'h11);
      chk("hold_funct3", issue_funct3, 5);
      chk("hold_free", free_count, 3);
      tick();
    end
    issue_ready = 1;
    tick();
    idle();
    chk("hold_released_free", free_count, 4);
    chk("hold_released_valid", issue_valid, 0);

    // Simultaneous issue and dispatch: the freed slot is not reused
    disp(1, 1, 0, 1, 1, 1, 0, 1, 2, 0);
    tick();
    idle();
    disp(1, 2, 0, 2, 1, 3, 0, 1, 4, 0); issue_ready = 1;
    tick();
    idle();
    chk("both_free", free_count, 3);
    chk("both_tag", issue_tag, 2);
    issue_ready = 1;
    tick();

    // Reset in mid-operation discards pending work
    idle();
    disp(1, 0, 0, 5, 1, 8, 0, 1, 9, 0);
    tick();
    idle();
    rst = 1; issue_ready = 1;
    disp(1, 0, 0, 6, 1, 8, 0, 1, 9, 0);
    tick();
    rst = 0;
    idle();
    chk("midrst_valid", issue_valid, 0);
    chk("midrst_free", free_count, 4);
    tick();

    // Randomized traffic against the model
    for (int c = 0; c < 600; c++) begin
      idle();
      rst = ($urandom_range(0, 63) == 0);
      flush = ($urandom_range(0, 31) == 0);
      if ($urandom_range(0, 1) == 1) begin
        disp(1'($urandom), 3'($urandom), 1'($urandom), 3'($urandom),
             ($urandom_range(0, 2) == 0), $urandom, 3'($urandom),
             ($urandom_range(0, 2) == 0), $urandom, 3'($urandom));
      end
      cdb_req = ($urandom_range(0, 1) == 1);
      cdb_tag = 3'($urandom);
      cdb_data = $urandom;
      issue_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    rst = 0;
    idle();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
